// File: rtl/neuron_config_loader_pkg.sv
// rtl/neuron_config_loader_pkg.sv - shared state encoding and count width for the neuron config loader
package neuron_config_loader_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/neuron_config_loader.sv
// rtl/neuron_config_loader.sv - streams weights and a bias per neuron into a layer's neurons
module neuron_config_loader
    import neuron_config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] layer_num,
    input  logic [15:0] num_neurons,
    input  logic [15:0] num_weights,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        weightValid,
    output logic        biasValid,
    output logic [31:0] weightValue,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e             state_q, state_d;
    logic [31:0]        layer_q, layer_d;
    logic [CNT_W-1:0]   nn_q, nn_d;
    logic [CNT_W-1:0]   nw_q, nw_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   ncnt_q, ncnt_d;
    logic [CNT_W-1:0]   cnrn_q, cnrn_d;
    logic               err_q, err_d;
    logic               wv_q, wv_d;
    logic               bv_q, bv_d;
    logic [31:0]        wval_q, wval_d;
    logic [31:0]        bval_q, bval_d;
    logic               beat;

    assign in_ready = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B);
    assign beat     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        nn_d    = nn_q;
        nw_d    = nw_q;
        wcnt_d  = wcnt_q;
        ncnt_d  = ncnt_q;
        cnrn_d  = cnrn_q;
        err_d   = err_q;
        wv_d    = 1'b0;
        bv_d    = 1'b0;
        wval_d  = wval_q;
        bval_d  = bval_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    layer_d = layer_num;
                    nn_d    = num_neurons;
                    nw_d    = num_weights;
                    wcnt_d  = '0;
                    ncnt_d  = '0;
                    err_d   = (num_neurons == '0) || (num_weights == '0);
                    state_d = err_d ? ST_FINISH : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (beat) begin
                    wv_d   = 1'b1;
                    wval_d = in_data;
                    cnrn_d = ncnt_q;
                    // compare against count-1 so a count of 65535 never needs a 17th bit
                    if (wcnt_q == nw_q - CNT_W'(1)) begin
                        wcnt_d  = '0;
                        state_d = ST_LOAD_B;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (beat) begin
                    bv_d   = 1'b1;
                    bval_d = in_data;
                    cnrn_d = ncnt_q;
                    if (ncnt_q == nn_q - CNT_W'(1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        ncnt_d  = ncnt_q + CNT_W'(1);
                        state_d = ST_LOAD_W;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            nn_q    <= '0;
            nw_q    <= '0;
            wcnt_q  <= '0;
            ncnt_q  <= '0;
            cnrn_q  <= '0;
            err_q   <= 1'b0;
            wv_q    <= 1'b0;
            bv_q    <= 1'b0;
            wval_q  <= '0;
            bval_q  <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            nn_q    <= nn_d;
            nw_q    <= nw_d;
            wcnt_q  <= wcnt_d;
            ncnt_q  <= ncnt_d;
            cnrn_q  <= cnrn_d;
            err_q   <= err_d;
            wv_q    <= wv_d;
            bv_q    <= bv_d;
            wval_q  <= wval_d;
            bval_q  <= bval_d;
        end
    end

    assign weightValid       = wv_q;
    assign biasValid         = bv_q;
    assign weightValue       = wval_q;
    assign biasValue         = bval_q;
    assign config_layer_num  = layer_q;
    assign config_neuron_num = {{(32-CNT_W){1'b0}}, cnrn_q};
    assign busy              = in_ready;
    assign done              = (state_q == ST_FINISH);
    assign err               = (state_q == ST_FINISH) && err_q;

endmodule

// File: tb/tb_neuron_config_loader.sv
// tb/tb_neuron_config_loader.sv - self-checking bench for neuron_config_loader
module tb_neuron_config_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] layer_num;
    logic [15:0] num_neurons;
    logic [15:0] num_weights;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        weightValid;
    logic        biasValid;
    logic [31:0] weightValue;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        busy;
    logic        done;
    logic        err;

    neuron_config_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_num(layer_num),
        .num_neurons(num_neurons), .num_weights(num_weights),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .weightValid(weightValid), .biasValid(biasValid),
        .weightValue(weightValue), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_bias;
        logic [31:0] value;
        logic [31:0] neuron;
        logic [31:0] layer;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stream[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] nmem[2][784];
    int          waddr[2];
    logic [31:0] nbias[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected output sequence: per neuron, nw weights then one bias, in stream order.
    task automatic build_model(input logic [31:0] layer, input int nn, input int nw, input bit rnd);
        exp_t e;
        exp_q.delete();
        stream.delete();
        if (nn == 0 || nw == 0) return;
        for (int n = 0; n < nn; n++) begin
            for (int k = 0; k <= nw; k++) begin
                logic [31:0] w;
                w = rnd ? $urandom : 32'(n * (nw + 1) + k + 1);
                stream.push_back(w);
                e.is_bias = (k == nw);
                e.value   = w;
                e.neuron  = 32'(n);
                e.layer   = layer;
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process plus two bench-side neurons that capture the broadcast.
    always @(negedge clk) begin
        if (!rst_n) begin
            waddr[0] = 0;
            waddr[1] = 0;
        end else begin
            if (weightValid && biasValid) chk("both_valid", 1, 0);
            if (weightValid || biasValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {weightValid, biasValid}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("kind", {biasValid, weightValid}, {e.is_bias, !e.is_bias});
                    chk("value", biasValid ? biasValue : weightValue, e.value);
                    chk("neuron", config_neuron_num, e.neuron);
                    chk("layer", config_layer_num, e.layer);
                end
                if (config_neuron_num < 2) begin
                    if (weightValid && waddr[config_neuron_num] < 784) begin
                        nmem[config_neuron_num][waddr[config_neuron_num]] = weightValue;
                        waddr[config_neuron_num]++;
                    end
                    if (biasValid) nbias[config_neuron_num] = biasValue;
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_flags", {in_ready, weightValid, biasValid, busy, done, err}, 0);
        chk("rst_values", {weightValue, biasValue}, 0);
        chk("rst_cfg", {config_layer_num, config_neuron_num}, 0);
    endtask

    task automatic do_load(input logic [31:0] layer, input int nn, input int nw,
                           input bit stall, input bit restart, input int rst_at,
                           input bit skip_build, input bit rnd, input int budget,
                           output int done_cyc, output logic err_seen);
        int idx = 0;
        int c = 0;
        bit fire;
        bit want;
        if (!skip_build) build_model(layer, nn, nw, rnd);
        done_cyc = -1;
        err_seen = 1'b0;
        start = 1'b1;
        layer_num = layer;
        num_neurons = 16'(nn);
        num_weights = 16'(nw);
        in_valid = 1'b0;
        while (c < budget) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (done) begin
                done_cyc = c;
                err_seen = err;
                chk("busy_at_done", {busy, in_ready}, 0);
                break;
            end
            if (c == 1 && nn != 0 && nw != 0) chk("busy_ready_c1", {busy, in_ready}, 2'b11);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (fire) idx++;
            c++;
            if (restart && c == 3) begin
                start = 1'b1;
                layer_num = 32'd99;
                num_neurons = 16'd7;
                num_weights = 16'd1;
            end
            if (rst_at > 0 && c == rst_at) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_outputs();
                exp_q.delete();
                repeat (2) begin
                    @(negedge clk);
                    chk("no_done_in_reset", done, 0);
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                done_cyc = -2;
                return;
            end
            want = stall ? (c % 2 == 0) : 1'b1;
            if (idx < stream.size() && want) begin
                in_valid = 1'b1;
                in_data = stream[idx];
            end else begin
                in_valid = 1'b0;
                in_data = 32'hBAD0_0000 | 32'(c);
            end
        end
        in_valid = 1'b0;
        if (done_cyc < 0) chk("timeout", 1, 0);
        @(posedge clk);
        #1;
        chk("words_consumed", idx, stream.size());
        chk("model_drained", exp_q.size(), 0);
    endtask

    initial begin
        int dc;
        logic ev;
        rst_n = 1'b0;
        start = 1'b0;
        layer_num = '0;
        num_neurons = '0;
        num_weights = '0;
        in_data = '0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pin the model against hand-computed values for layer 1, 2x3.
        build_model(32'd1, 2, 3, 0);
        chk("pin_w1", exp_q[1].value, 2);
        chk("pin_b0", {exp_q[3].is_bias, exp_q[3].value, exp_q[3].neuron}, {1'b1, 32'd4, 32'd0});
        chk("pin_w5", {exp_q[4].is_bias, exp_q[4].value, exp_q[4].neuron}, {1'b0, 32'd5, 32'd1});
        chk("pin_b1", {exp_q[7].is_bias, exp_q[7].value}, {1'b1, 32'd8});

        do_load(32'd1, 2, 3, 0, 0, 0, 1, 0, 100, dc, ev);
        chk("cont_done_cycle", dc, 9);
        chk("cont_err", ev, 0);

        do_load(32'd1, 2, 3, 1, 0, 0, 0, 0, 100, dc, ev);
        chk("stall_done_cycle", dc, 17);
        chk("stall_err", ev, 0);

        do_load(32'd5, 2, 0, 0, 0, 0, 0, 0, 20, dc, ev);
        chk("zero_w_done_cycle", dc, 1);
        chk("zero_w_err", ev, 1);

        do_load(32'd6, 0, 4, 0, 0, 0, 0, 0, 20, dc, ev);
        chk("zero_n_done_cycle", dc, 1);
        chk("zero_n_err", ev, 1);

        do_load(32'd1, 2, 3, 0, 1, 0, 0, 0, 100, dc, ev);
        chk("restart_done_cycle", dc, 9);
        chk("restart_err", ev, 0);

        do_load(32'd1, 2, 3, 0, 0, 3, 0, 0, 100, dc, ev);
        chk("reset_abandon", dc, -2);
        do_load(32'd3, 3, 2, 0, 0, 0, 0, 0, 100, dc, ev);
        chk("fresh_done_cycle", dc, 10);

        // Two neurons, 784 weights each; reset first so the bench neurons re-arm.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_load(32'd2, 2, 784, 0, 0, 0, 0, 1, 2000, dc, ev);
        chk("big_done_cycle", dc, 1571);
        for (int n = 0; n < 2; n++) begin
            int bad = 0;
            for (int w = 0; w < 784; w++)
                if (nmem[n][w] !== stream[n * 785 + w]) bad++;
            chk($sformatf("neuron%0d_mem_mismatches", n), bad, 0);
            chk($sformatf("neuron%0d_waddr", n), waddr[n], 784);
            chk($sformatf("neuron%0d_bias", n), nbias[n], stream[n * 785 + 784]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
